// File: rtl/cache_if.sv
// cache_if: CPU load/store port and word-wide memory port of cache_ctrl.
interface cache_if;
  logic        cpu_req, cpu_we, cpu_ready, mem_req, mem_we, mem_ack;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, mem_addr, mem_wdata, mem_rdata;
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
    output cpu_rdata, cpu_ready, mem_req, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
    input  cpu_rdata, cpu_ready, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_ctrl.sv
// cache_ctrl: N-way set-associative write-through, no-write-allocate data cache with blocking refill.
// Defining CACHE_STATS_EN adds saturating hit_count/miss_count outputs.
module cache_ctrl #(
  parameter int NUM_SETS    = 16,
  parameter int NUM_WAYS    = 2,
  parameter int BLOCK_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
`ifdef CACHE_STATS_EN
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
`endif
  cache_if.slave      bus
);
  localparam int OFF_W = $clog2(BLOCK_WORDS);
  localparam int SET_W = $clog2(NUM_SETS);
  localparam int TAG_W = 30 - OFF_W - SET_W;
  localparam int WAY_W = NUM_WAYS > 1 ? $clog2(NUM_WAYS) : 1;
  typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;
  state_t           state_q;
  logic [31:0]      data_q  [NUM_SETS][NUM_WAYS][BLOCK_WORDS];
  logic [TAG_W-1:0] tag_q   [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
  logic [WAY_W-1:0] vptr_q  [NUM_SETS];
  logic [OFF_W-1:0] beat_q;
  logic [WAY_W-1:0] victim_q, hit_way, inv_way;
  logic             from_vptr_q, hit, inv, last_beat;
  logic             mem_req_q, mem_we_q;
  logic [31:0]      mem_addr_q, mem_wdata_q;
  logic [TAG_W-1:0] tag_a;
  logic [SET_W-1:0] set_a;
  logic [OFF_W-1:0] off_a;
  assign tag_a = bus.cpu_addr[31 -: TAG_W];
  assign set_a = bus.cpu_addr[2+OFF_W +: SET_W];
  assign off_a = bus.cpu_addr[2 +: OFF_W];
  // Descending scan so the lowest-index invalid way wins victim selection.
  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    inv = 1'b0;
    inv_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid_q[set_a][w] && tag_q[set_a][w] == tag_a) begin
        hit = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[set_a][w]) begin
        inv = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
  end
  assign last_beat     = state_q == REFILL && bus.mem_ack && &beat_q;
  assign bus.cpu_ready = state_q == IDLE ? bus.cpu_req && !bus.cpu_we && hit
                                         : state_q == WRITE && bus.mem_ack;
  assign bus.cpu_rdata = bus.cpu_ready && !bus.cpu_we ? data_q[set_a][hit_way][off_a] : '0;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      victim_q    <= '0;
      from_vptr_q <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        vptr_q[s]  <= '0;
      end
    end else begin
      case (state_q)
        IDLE:
          if (bus.cpu_req && bus.cpu_we) begin
            state_q     <= WRITE;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= {bus.cpu_addr[31:2], 2'b00};
            mem_wdata_q <= bus.cpu_wdata;
          end else if (bus.cpu_req && !hit) begin
            state_q     <= REFILL;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            beat_q      <= '0;
            victim_q    <= inv ? inv_way : vptr_q[set_a];
            from_vptr_q <= !inv;
            mem_addr_q  <= {tag_a, set_a, {OFF_W{1'b0}}, 2'b00};
          end
        REFILL:
          if (bus.mem_ack) begin
            beat_q <= beat_q + 1'b1;
            mem_addr_q[2 +: OFF_W] <= beat_q + 1'b1;
            if (&beat_q) begin
              state_q <= IDLE;
              mem_req_q <= 1'b0;
              valid_q[set_a][victim_q] <= 1'b1;
              if (from_vptr_q && NUM_WAYS > 1) vptr_q[set_a] <= vptr_q[set_a] + 1'b1;
            end
          end
        default:
          if (bus.mem_ack) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
          end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (state_q == REFILL && bus.mem_ack) data_q[set_a][victim_q][beat_q] <= bus.mem_rdata;
    if (last_beat) tag_q[set_a][victim_q] <= tag_a;
    if (state_q == WRITE && bus.mem_ack && hit) data_q[set_a][hit_way][off_a] <= bus.cpu_wdata;
  end
`ifdef CACHE_STATS_EN
  logic replay_q, hit_inc, miss_inc;
  assign hit_inc  = (state_q == IDLE && bus.cpu_ready && !replay_q) ||
                    (state_q == WRITE && bus.mem_ack && hit);
  assign miss_inc = (state_q == IDLE && bus.cpu_req && !bus.cpu_we && !hit) ||
                    (state_q == WRITE && bus.mem_ack && !hit);
  // The hit that replays a just-refilled load is not a new access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      replay_q   <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      replay_q <= last_beat;
      if (hit_inc && ~&hit_count) hit_count <= hit_count + 1'b1;
      if (miss_inc && ~&miss_count) miss_count <= miss_count + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: directed scoreboard bench for cache_ctrl; CPU and memory monitors pop expected queues.
module tb_cache_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  cache_if bus();
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif
  cache_ctrl dut (
    .clk(clk),
    .rst(rst),
`ifdef CACHE_STATS_EN
    .hit_count(hit_count),
    .miss_count(miss_count),
`endif
    .bus(bus)
  );
  typedef struct {logic [31:0] rdata; int lat;} cpu_exp_t;
  typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata;} mem_exp_t;
  cpu_exp_t cpu_q[$];
  mem_exp_t mem_q[$];
  cpu_exp_t ce;
  mem_exp_t me;
  logic [31:0] mem [logic [31:0]];
  int checks = 0, errors = 0, cyc = 0, start_cyc = 0, stall = 0, wcnt = 0;
  logic pend = 1'b0;
  logic [31:0] pend_addr;
  always @(posedge clk) cyc++;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : {16'hC0DE, a[15:0]};
  endfunction
  // Memory responder: ack after `stall` wait cycles per beat, driven just after the clock edge.
  always @(posedge clk) begin
    #1;
    if (bus.mem_req && !rst) begin
      if (wcnt >= stall) begin
        bus.mem_ack = 1'b1;
        bus.mem_rdata = bus.mem_we ? 32'h0 : mem_rd(bus.mem_addr);
        wcnt = 0;
      end else begin
        bus.mem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      bus.mem_ack = 1'b0;
      wcnt = 0;
    end
  end
  always @(negedge clk) begin
    if (rst) pend = 1'b0;
    else begin
      if (pend) begin
        chk("stall_req", {31'b0, bus.mem_req}, 32'd1);
        chk("stall_addr", bus.mem_addr, pend_addr);
      end
      if (bus.mem_req && !bus.mem_ack) begin
        chk("stall_ready", {31'b0, bus.cpu_ready}, 32'd0);
        pend = 1'b1;
        pend_addr = bus.mem_addr;
      end else pend = 1'b0;
      if (bus.mem_req && bus.mem_ack) begin
        if (mem_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mem_unexpected: got beat at %h expected none", bus.mem_addr);
        end else begin
          me = mem_q.pop_front();
          chk("mem_we", {31'b0, bus.mem_we}, {31'b0, me.we});
          chk("mem_addr", bus.mem_addr, me.addr);
          if (me.we) chk("mem_wdata", bus.mem_wdata, me.wdata);
        end
        if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
      end
      if (bus.cpu_ready) begin
        if (cpu_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL cpu_unexpected: got ready at addr %h expected none", bus.cpu_addr);
        end else begin
          ce = cpu_q.pop_front();
          chk("cpu_rdata", bus.cpu_rdata, ce.rdata);
          chk("latency", cyc - start_cyc + 1, ce.lat);
        end
      end
    end
  end
  task automatic exp_rd4(input logic [31:0] base);
    for (int i = 0; i < 4; i++) mem_q.push_back('{1'b0, base + 32'(4 * i), 32'h0});
  endtask
  task automatic exp_wr(input logic [31:0] addr, input logic [31:0] data);
    mem_q.push_back('{1'b1, addr, data});
  endtask
  // Called just after a rising edge; returns just after the edge following cpu_ready.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int lat);
    int n;
    cpu_q.push_back('{rdata, lat});
    bus.cpu_req = 1'b1;
    bus.cpu_we = we;
    bus.cpu_addr = addr;
    bus.cpu_wdata = wdata;
    start_cyc = cyc;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.cpu_ready && n < 200);
    if (!bus.cpu_ready) begin
      checks++;
      errors++;
      $display("FAIL timeout: got no ready at addr %h expected ready", addr);
    end
    @(posedge clk);
    #1 bus.cpu_req = 1'b0;
  endtask
  task automatic do_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end
  initial begin
    bus.cpu_req = 1'b0;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_wdata = '0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    for (int i = 0; i < 4; i++) mem[32'h40 + 32'(4 * i)] = 32'hA0 + 32'(i);
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_mem_req", {31'b0, bus.mem_req}, 32'd0);
    chk("rst_mem_we", {31'b0, bus.mem_we}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_cpu_ready", {31'b0, bus.cpu_ready}, 32'd0);
    chk("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    exp_rd4(32'h40);
    access(1'b0, 32'h40, 32'h0, 32'hA0, 6);
    access(1'b0, 32'h48, 32'h0, 32'hA2, 1);
    exp_wr(32'h44, 32'hDEAD_BEEF);
    access(1'b1, 32'h44, 32'hDEAD_BEEF, 32'h0, 2);
    exp_wr(32'h1000, 32'h1234_5678);
    access(1'b1, 32'h1000, 32'h1234_5678, 32'h0, 2);
`ifdef CACHE_STATS_EN
    chk("hit_count", hit_count, 32'd2);
    chk("miss_count", miss_count, 32'd2);
`endif
    access(1'b0, 32'h44, 32'h0, 32'hDEAD_BEEF, 1);
    exp_rd4(32'h1000);
    access(1'b0, 32'h1000, 32'h0, 32'h1234_5678, 6);
    do_reset();
    exp_rd4(32'h000);
    access(1'b0, 32'h000, 32'h0, 32'hC0DE_0000, 6);
    exp_rd4(32'h400);
    access(1'b0, 32'h400, 32'h0, 32'hC0DE_0400, 6);
    exp_rd4(32'h800);
    access(1'b0, 32'h800, 32'h0, 32'hC0DE_0800, 6);
    access(1'b0, 32'h404, 32'h0, 32'hC0DE_0404, 1);
    exp_rd4(32'h000);
    access(1'b0, 32'h000, 32'h0, 32'hC0DE_0000, 6);
    stall = 5;
    exp_rd4(32'h80);
    access(1'b0, 32'h80, 32'h0, 32'hC0DE_0080, 26);
    bus.cpu_req = 1'b1;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = 32'hC0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_mem_req", {31'b0, bus.mem_req}, 32'd0);
    chk("rst_mid_ready", {31'b0, bus.cpu_ready}, 32'd0);
    bus.cpu_req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    stall = 0;
    @(posedge clk);
    #1;
    exp_rd4(32'hC0);
    access(1'b0, 32'hC0, 32'h0, 32'hC0DE_00C0, 6);
    repeat (3) @(posedge clk);
    chk("cpu_queue_empty", cpu_q.size(), 32'd0);
    chk("mem_queue_empty", mem_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
